// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter/sequencer sharing one UART_tx among NREQ byte producers.
//
// Optional feature macro: UART_ARB_LOCK_EN (adds the lock input for back-to-back packets).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req      [NREQ]    level request per requester, held until its ack
//   req_data [8*NREQ]  byte of requester i at [8i+7:8i]
//   lock     [NREQ]    (UART_ARB_LOCK_EN only) keep the grant on the current requester
//   ack      [NREQ]    one-cycle pulse: byte of requester i captured and launched
//   done     [NREQ]    one-cycle pulse: byte of requester i fully shifted out
//   err                one-cycle pulse on watchdog timeout
//   busy               state is not IDLE
//   trmt, tx_data      launch strobe and byte to UART_tx (tx_data registered)
//   tx_done            frame-complete level from UART_tx
module uart_tx_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TMO_CYC = 8191
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NREQ-1:0]   lock,
`endif
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic              busy,
  output logic              trmt,
  output logic [7:0]        tx_data,
  input  logic              tx_done
);

  localparam int unsigned     IdxW    = $clog2(NREQ);
  localparam int unsigned     WdW     = $clog2(TMO_CYC + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NREQ - 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TMO_CYC - 1);
  localparam logic [NREQ-1:0] OneHot0 = NREQ'(1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [WdW-1:0]  wdog_q, wdog_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;
  // Current grant is a locked re-grant, so the round-robin pointer must hold.
  logic            relock_q, relock_d;

  logic            rr_found;
  logic [IdxW-1:0] rr_idx;
  logic            regrant;

  // Locked re-grant is only possible in the IDLE cycle that carries done for the
  // current holder; a timeout pulses no done, so it drops the lock by construction.
`ifdef UART_ARB_LOCK_EN
  assign regrant = (|done_q) & lock[gnt_idx_q] & req[gnt_idx_q];
`else
  assign regrant = 1'b0;
`endif

  // First requesting index at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!rr_found && req[(32'(rr_ptr_q) + k) % NREQ]) begin
        rr_found = 1'b1;
        rr_idx   = IdxW'((32'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    tx_data_d = tx_data_q;
    wdog_d    = wdog_q;
    done_d    = '0;
    err_d     = 1'b0;
    relock_d  = relock_q;
    unique case (state_q)
      StIdle: begin
        if (regrant) begin
          tx_data_d = req_data[8*gnt_idx_q +: 8];
          relock_d  = 1'b1;
          state_d   = StLaunch;
        end else if (rr_found) begin
          gnt_idx_d = rr_idx;
          tx_data_d = req_data[8*rr_idx +: 8];
          relock_d  = 1'b0;
          state_d   = StLaunch;
        end
      end
      StLaunch: begin
        if (!relock_q) begin
          rr_ptr_d = (gnt_idx_q == LastIdx) ? '0 : gnt_idx_q + 1'b1;
        end
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (wdog_q != '1) begin
          wdog_d = wdog_q + 1'b1;
        end
        if (tx_done) begin
          done_d  = OneHot0 << gnt_idx_q;
          state_d = StIdle;
        end else if (wdog_q == WdLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      tx_data_q <= 8'h00;
      wdog_q    <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      relock_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      tx_data_q <= tx_data_d;
      wdog_q    <= wdog_d;
      done_q    <= done_d;
      err_q     <= err_d;
      relock_q  <= relock_d;
    end
  end

  // Strobes decode from registered state only, never from req.
  assign busy    = (state_q != StIdle);
  assign trmt    = (state_q == StLaunch);
  assign ack     = trmt ? (OneHot0 << gnt_idx_q) : '0;
  assign done    = done_q;
  assign err     = err_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed self-checking bench for uart_tx_arb with a behavioural UART_tx.
// Define UART_ARB_LOCK_EN for both files to include the lock sequence.
module tb_uart_tx_arb;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TMO_CYC = 8191;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
`ifdef UART_ARB_LOCK_EN
  logic [3:0]  lock = '0;
`endif
  logic [3:0]  ack, done;
  logic        err, busy, trmt, tx_done;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  uart_tx_arb #(.NREQ(NREQ), .TMO_CYC(TMO_CYC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
`ifdef UART_ARB_LOCK_EN
    .lock     (lock),
`endif
    .ack      (ack),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .tx_done  (tx_done)
  );

  // Behavioural UART_tx: start/8 data LSB first/stop, bit_cyc clocks per bit.
  int unsigned bit_cyc = 435;
  logic        hang = 1'b0;
  logic [9:0]  sh_q;
  logic        txb_q, txd_q, tx_line;
  int unsigned cyc_q, bit_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '1; txb_q <= 1'b0; txd_q <= 1'b0; cyc_q <= 0; bit_q <= 0;
    end else if (trmt) begin
      sh_q <= {1'b1, tx_data, 1'b0}; txb_q <= 1'b1; txd_q <= 1'b0; cyc_q <= 0; bit_q <= 0;
    end else if (txb_q) begin
      if (cyc_q == bit_cyc - 1) begin
        cyc_q <= 0;
        sh_q  <= {1'b1, sh_q[9:1]};
        bit_q <= bit_q + 1;
        if (bit_q == 9) begin
          txb_q <= 1'b0;
          txd_q <= !hang;
        end
      end else begin
        cyc_q <= cyc_q + 1;
      end
    end
  end
  assign tx_done = txd_q;
  assign tx_line = txb_q ? sh_q[0] : 1'b1;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned done_cnt = 0, bad_cnt = 0;
  always @(negedge clk) begin
    if (done != 0) done_cnt <= done_cnt + 1;
    if (!$onehot0(ack) || !$onehot0(done) || (ack != 0 && done != 0)) bad_cnt <= bad_cnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag, input int unsigned limit);
    int unsigned n = 0;
    do begin @(negedge clk); n++; end while (ack == 0 && n < limit);
    check({tag, " ack seen"}, 32'(ack != 0), 1);
  endtask

  task automatic wait_done(input string tag, input int unsigned limit);
    int unsigned n = 0;
    do begin @(negedge clk); n++; end while (done == 0 && n < limit);
    check({tag, " done seen"}, 32'(done != 0), 1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [9:0]  frame_obs;
  int unsigned t0, d0, n;
  int          exp3 [4] = '{0, 3, 0, 3};

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst busy", 32'(busy), 0);
    check("rst trmt", 32'(trmt), 0);
    check("rst ack", 32'(ack), 0);
    check("rst done", 32'(done), 0);
    check("rst err", 32'(err), 0);
    check("rst tx_data", 32'(tx_data), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle busy", 32'(busy), 0);

    // Single byte 0xA5 on requester 2, full-rate frame
    req_data = 32'h44A52211;
    req      = 4'b0100;
    @(negedge clk);
    check("t1 ack", 32'(ack), 32'h4);
    check("t1 trmt", 32'(trmt), 1);
    check("t1 busy", 32'(busy), 1);
    check("t1 tx_data", 32'(tx_data), 32'hA5);
    req      = '0;
    req_data = '0;
    @(negedge clk);
    check("t1 ack one cycle", 32'(ack), 0);
    check("t1 tx_data held", 32'(tx_data), 32'hA5);
    repeat (217) @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      frame_obs[b] = tx_line;
      if (b < 9) repeat (435) @(negedge clk);
    end
    check("t1 frame", 32'(frame_obs), 32'h34A);
    n = 0;
    while (tx_done == 1'b0 && n < 1000) begin @(negedge clk); n++; end
    check("t1 tx_done seen", 32'(tx_done), 1);
    check("t1 done before", 32'(done), 0);
    check("t1 busy in wait", 32'(busy), 1);
    @(negedge clk);
    check("t1 done", 32'(done), 32'h4);
    check("t1 busy after", 32'(busy), 0);
    @(negedge clk);
    check("t1 done one cycle", 32'(done), 0);

    // Simultaneous requests from a fresh pointer
    bit_cyc = 2;
    pulse_reset();
    req_data = 32'h44332211;
    req      = 4'b1111;
    d0       = done_cnt;
    for (int i = 0; i < 4; i++) begin
      wait_ack("t2", 100);
      check("t2 grant", 32'(ack), 32'(1 << i));
      check("t2 tx_data", 32'(tx_data), 32'(17 * (i + 1)));
      req[i] = 1'b0;
    end
    wait_done("t2 last", 100);
    check("t2 last done", 32'(done), 32'h8);
    @(negedge clk);
    check("t2 done count", done_cnt - d0, 4);
    check("t2 one-hot", bad_cnt, 0);

    // Fairness: 0 and 3 held, back-to-back grants alternate and wrap
    req_data = 32'hD3C2B1A0;
    req      = 4'b1001;
    for (int j = 0; j < 4; j++) begin
      if (j == 0) wait_ack("t3", 100);
      else @(negedge clk);
      check("t3 grant", 32'(ack), 32'(1 << exp3[j]));
      check("t3 tx_data", 32'(tx_data), (exp3[j] == 0) ? 32'hA0 : 32'hD3);
      if (j == 3) req = '0;
      wait_done("t3", 100);
      check("t3 done", 32'(done), 32'(1 << exp3[j]));
    end

    // Watchdog timeout
    hang     = 1'b1;
    req_data = 32'h00005A00;
    req      = 4'b0010;
    wait_ack("t4", 100);
    t0 = cyc;
    check("t4 grant", 32'(ack), 32'h2);
    req = '0;
    d0  = done_cnt;
    n   = 0;
    do begin @(negedge clk); n++; end while (err == 1'b0 && n < TMO_CYC + 20);
    check("t4 err seen", 32'(err), 1);
    check("t4 err latency", cyc - t0, TMO_CYC + 1);
    check("t4 busy at err", 32'(busy), 0);
    @(negedge clk);
    check("t4 err one cycle", 32'(err), 0);
    check("t4 no done", done_cnt - d0, 0);
    hang     = 1'b0;
    req_data = 32'h00000077;
    req      = 4'b0001;
    wait_ack("t4 next", 100);
    check("t4 next grant", 32'(ack), 32'h1);
    check("t4 next tx_data", 32'(tx_data), 32'h77);
    req = '0;
    wait_done("t4 next", 100);
    check("t4 next done", 32'(done), 32'h1);

    // Reset mid-frame
    bit_cyc  = 435;
    req_data = 32'hC3000000;
    req      = 4'b1000;
    wait_ack("t5", 100);
    check("t5 grant", 32'(ack), 32'h8);
    req = '0;
    repeat (1000) @(negedge clk);
    check("t5 busy mid", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t5 rst busy", 32'(busy), 0);
    check("t5 rst trmt", 32'(trmt), 0);
    check("t5 rst ack", 32'(ack), 0);
    check("t5 rst done", 32'(done), 0);
    check("t5 rst err", 32'(err), 0);
    check("t5 rst tx_data", 32'(tx_data), 0);
    check("t5 rst line", 32'(tx_line), 1);
    @(negedge clk);
    rst_n    = 1'b1;
    bit_cyc  = 2;
    req_data = 32'h00960000;
    req      = 4'b0100;
    wait_ack("t5 fresh", 100);
    check("t5 fresh grant", 32'(ack), 32'h4);
    check("t5 fresh tx_data", 32'(tx_data), 32'h96);
    req = '0;
    wait_done("t5 fresh", 100);
    check("t5 fresh done", 32'(done), 32'h4);
    @(negedge clk);
    check("t5 idle", 32'(busy), 0);

`ifdef UART_ARB_LOCK_EN
    // Locked 3-byte packet on requester 1 while requester 0 waits
    pulse_reset();
    lock     = 4'b0010;
    req_data = 32'h00000100;
    req      = 4'b0010;
    wait_ack("t6", 100);
    check("t6 grant1", 32'(ack), 32'h2);
    check("t6 byte1", 32'(tx_data), 32'h01);
    req[0]   = 1'b1;
    req_data = 32'h00000200;
    wait_done("t6 b1", 100);
    @(negedge clk);
    check("t6 grant2", 32'(ack), 32'h2);
    check("t6 byte2", 32'(tx_data), 32'h02);
    req_data = 32'h00000300;
    wait_done("t6 b2", 100);
    @(negedge clk);
    check("t6 grant3", 32'(ack), 32'h2);
    check("t6 byte3", 32'(tx_data), 32'h03);
    req[1] = 1'b0;
    wait_done("t6 b3", 100);
    @(negedge clk);
    check("t6 grant0", 32'(ack), 32'h1);
    req = '0;
    wait_done("t6 b4", 100);
    lock = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
